// File: rtl/soc_spi_sram_pkg.sv
// ---------------------------------------------------------------------------
// soc_spi_sram_pkg
// Shared definitions for the SPI SRAM controller:
//   - 23LC-style SPI opcodes
//   - controller FSM state encoding
//   - frame-length constants and helpers
// ---------------------------------------------------------------------------
package soc_spi_sram_pkg;

    localparam logic [7:0] SPI_OP_READ  = 8'h03;
    localparam logic [7:0] SPI_OP_WRITE = 8'h02;

    // Frame pieces, in bits
    localparam int SPI_CMD_BITS  = 8;
    localparam int SPI_WORD_BITS = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Total frame length: opcode + address + payload bytes
    function automatic int frame_bits(input int addr_bytes, input int data_bytes);
        return 8 * (1 + addr_bytes + data_bytes);
    endfunction

    // Reverse byte order of a 32-bit word
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/soc_spi_sram_ctrl_wmask_span.sv
// ---------------------------------------------------------------------------
// soc_wmask_span
// Combinational: reduces a 4-bit byte-enable mask to the contiguous span
// that covers every enabled lane.
//   wmask_i : byte enables (lane 0 = bits [7:0])
//   start_o : index of the lowest enabled lane (0 when mask is empty)
//   len_o   : highest enabled index - start + 1 (0 when mask is empty)
// Holes inside the span are counted as part of it.
// ---------------------------------------------------------------------------
module soc_wmask_span
    import soc_spi_sram_pkg::*;
(
    input  logic [3:0] wmask_i,
    output logic [1:0] start_o,
    output logic [2:0] len_o
);

    logic [1:0] last_idx;
    logic       found;

    always_comb begin
        start_o  = 2'd0;
        last_idx = 2'd0;
        found    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (wmask_i[i]) begin
                if (!found) begin
                    start_o = 2'(i);
                end
                found    = 1'b1;
                last_idx = 2'(i);
            end
        end
        len_o = found ? (3'(last_idx) - 3'(start_o) + 3'd1) : 3'd0;
    end

endmodule

// File: rtl/soc_spi_sram_ctrl.sv
// ---------------------------------------------------------------------------
// soc_spi_sram_ctrl
// Serialises single-master word-addressed SRAM requests into SPI mode-0
// frames for a 23LC-style serial SRAM.
//
// Ports:
//   clk             system clock (SPI clock is clk/2)
//   i_rst_n         synchronous active-low reset
//   sram_addr       word address; byte address = {addr[8*AB-3:0],2'b00}
//   sram_data_write write data, little-endian lanes
//   sram_we         1 = write, 0 = read
//   sram_cs         request valid, held until sram_ack
//   sram_wmask      write byte enables
//   sram_data_read  read data, valid at ack, held until next read completes
//   sram_ack        one-cycle completion pulse
//   spi_cs_n        SRAM chip select (active low)
//   spi_sck         SPI clock, idle low
//   spi_mosi        serial out, MSB first
//   spi_miso        serial in
// ---------------------------------------------------------------------------
module soc_spi_sram_ctrl
    import soc_spi_sram_pkg::*;
#(
    parameter int ADDR_BYTES = 3
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_data_write,
    input  logic        sram_we,
    input  logic        sram_cs,
    input  logic [3:0]  sram_wmask,
    output logic [31:0] sram_data_read,
    output logic        sram_ack,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int AW = 8 * ADDR_BYTES;
    localparam int FW = frame_bits(ADDR_BYTES, SPI_WORD_BITS / 8);
    localparam int CW = $clog2(FW + 1);

    // -----------------------------------------------------------------------
    // Write span decode
    // -----------------------------------------------------------------------
    logic [1:0] span_start;
    logic [2:0] span_len;

    soc_wmask_span u_span (
        .wmask_i (sram_wmask),
        .start_o (span_start),
        .len_o   (span_len)
    );

    // -----------------------------------------------------------------------
    // Frame construction from the live request. The frame is left-aligned
    // in a full-length vector; shorter write frames simply stop early.
    // -----------------------------------------------------------------------
    logic [AW-1:0] byte_addr;
    logic [31:0]   wr_payload;
    logic [FW-1:0] frame_d;
    logic [CW-1:0] last_bit_d;
    logic          empty_write_d;

    always_comb begin
        byte_addr     = {sram_addr[AW-3:0], 2'b00};
        // Shift lane s down to [7:0] then byte-swap so it leaves first.
        wr_payload    = bswap32(sram_data_write >> {span_start, 3'b000});
        empty_write_d = sram_we && (sram_wmask == 4'b0000);
        if (sram_we) begin
            frame_d    = {SPI_OP_WRITE, byte_addr + AW'(span_start), wr_payload};
            last_bit_d = CW'(frame_bits(ADDR_BYTES, int'(span_len)) - 1);
        end else begin
            frame_d    = {SPI_OP_READ, byte_addr, 32'h0000_0000};
            last_bit_d = CW'(FW - 1);
        end
    end

    // Upper address bits are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^sram_addr[31:AW-2];

    // -----------------------------------------------------------------------
    // Controller FSM with registered outputs
    // -----------------------------------------------------------------------
    state_e        state_q;
    logic [FW-1:0] tx_q;       // bits still to send, next one at MSB
    logic [31:0]   rx_q;       // received bits, oldest at MSB
    logic [CW-1:0] cnt_q;      // bits remaining after the current one
    logic          phase_q;    // 0 = sck low phase, 1 = sck high phase
    logic          we_q;
    logic          spi_cs_n_q;
    logic          spi_sck_q;
    logic          spi_mosi_q;
    logic          ack_q;
    logic [31:0]   rdata_q;

    logic [31:0]   rx_d;
    assign rx_d = {rx_q[30:0], spi_miso};

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            we_q       <= 1'b0;
            spi_cs_n_q <= 1'b1;
            spi_sck_q  <= 1'b0;
            spi_mosi_q <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_q <= 1'b0;
                    if (sram_cs) begin
                        we_q <= sram_we;
                        if (empty_write_d) begin
                            // Nothing to write: complete without touching SPI.
                            state_q <= ST_DONE;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q    <= ST_SHIFT;
                            spi_cs_n_q <= 1'b0;
                            spi_sck_q  <= 1'b0;
                            phase_q    <= 1'b0;
                            spi_mosi_q <= frame_d[FW-1];
                            tx_q       <= {frame_d[FW-2:0], 1'b0};
                            cnt_q      <= last_bit_d;
                        end
                    end
                end

                ST_SHIFT: begin
                    if (!phase_q) begin
                        phase_q   <= 1'b1;
                        spi_sck_q <= 1'b1;
                    end else begin
                        // End of high phase: sample MISO, drop SCK.
                        phase_q   <= 1'b0;
                        spi_sck_q <= 1'b0;
                        rx_q      <= rx_d;
                        if (cnt_q == '0) begin
                            state_q    <= ST_DONE;
                            spi_cs_n_q <= 1'b1;
                            spi_mosi_q <= 1'b0;
                            ack_q      <= 1'b1;
                            // The last 32 received bits are the data bytes,
                            // first byte belonging in [7:0].
                            if (!we_q) begin
                                rdata_q <= bswap32(rx_d);
                            end
                        end else begin
                            cnt_q      <= cnt_q - 1'b1;
                            spi_mosi_q <= tx_q[FW-1];
                            tx_q       <= {tx_q[FW-2:0], 1'b0};
                        end
                    end
                end

                ST_DONE: begin
                    // Request is still held high here; never re-accept it.
                    ack_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sram_data_read = rdata_q;
    assign sram_ack       = ack_q;
    assign spi_cs_n       = spi_cs_n_q;
    assign spi_sck        = spi_sck_q;
    assign spi_mosi       = spi_mosi_q;

endmodule

// File: tb/tb_soc_spi_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_soc_spi_sram_ctrl
// Self-checking bench: a behavioural 23LC SPI SRAM device drives MISO and
// records MOSI bytes; a byte-level reference memory predicts read data,
// frame contents and latencies from the request alone.
// ---------------------------------------------------------------------------
module tb_soc_spi_sram_ctrl;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] sram_addr = '0;
    logic [31:0] sram_data_write = '0;
    logic        sram_we = 1'b0;
    logic        sram_cs = 1'b0;
    logic [3:0]  sram_wmask = '0;
    logic [31:0] sram_data_read;
    logic        sram_ack;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_rdata = '0;

    soc_spi_sram_ctrl dut (
        .clk             (clk),
        .i_rst_n         (i_rst_n),
        .sram_addr       (sram_addr),
        .sram_data_write (sram_data_write),
        .sram_we         (sram_we),
        .sram_cs         (sram_cs),
        .sram_wmask      (sram_wmask),
        .sram_data_read  (sram_data_read),
        .sram_ack        (sram_ack),
        .spi_cs_n        (spi_cs_n),
        .spi_sck         (spi_sck),
        .spi_mosi        (spi_mosi),
        .spi_miso        (spi_miso)
    );

    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Memories: ref_mem = expected SRAM contents, dev_mem = device contents
    // -----------------------------------------------------------------------
    logic [7:0] ref_mem [int];
    logic [7:0] dev_mem [int];

    function automatic logic [7:0] dflt(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [23:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return dflt(a);
    endfunction

    function automatic logic [7:0] dev_rd(input logic [23:0] a);
        if (dev_mem.exists(int'(a))) return dev_mem[int'(a)];
        return dflt(a);
    endfunction

    // -----------------------------------------------------------------------
    // SPI mode-0 SRAM device model
    // -----------------------------------------------------------------------
    logic [7:0]  dev_bytes [$];
    int          dev_bits = 0;
    logic [7:0]  dev_shift = '0;
    logic [7:0]  dev_op = '0;
    logic [23:0] dev_addr = '0;
    logic        prev_sck = 1'b0;
    logic        prev_csn = 1'b1;

    initial begin
        int          k;
        int          b;
        logic [23:0] a;
        logic [7:0]  v;
        spi_miso = 1'b0;
        forever begin
            @(spi_sck or spi_cs_n);
            if (prev_csn === 1'b1 && spi_cs_n === 1'b0) begin
                dev_bits  = 0;
                dev_shift = '0;
                dev_bytes.delete();
            end
            if (spi_cs_n === 1'b0 && prev_sck === 1'b0 && spi_sck === 1'b1) begin
                dev_shift = {dev_shift[6:0], spi_mosi};
                dev_bits++;
                if (dev_bits % 8 == 0) begin
                    dev_bytes.push_back(dev_shift);
                    if (dev_bits == 8) begin
                        dev_op = dev_shift;
                    end else if (dev_bits <= 32) begin
                        dev_addr = {dev_addr[15:0], dev_shift};
                    end else if (dev_op == 8'h02) begin
                        a = dev_addr + 24'(dev_bits / 8 - 5);
                        dev_mem[int'(a)] = dev_shift;
                    end
                end
            end
            if (spi_cs_n === 1'b0 && prev_sck === 1'b1 && spi_sck === 1'b0 &&
                dev_op == 8'h03 && dev_bits >= 32) begin
                k = (dev_bits - 32) / 8;
                b = 7 - ((dev_bits - 32) % 8);
                a = dev_addr + 24'(k);
                v = dev_rd(a);
                spi_miso = v[b];
            end
            prev_sck = spi_sck;
            prev_csn = spi_cs_n;
        end
    end

    // -----------------------------------------------------------------------
    // One request, fully checked against the reference model
    // -----------------------------------------------------------------------
    task automatic do_txn(input string name, input logic [31:0] addr,
                          input logic [31:0] data, input logic we,
                          input logic [3:0] mask, input bit mutate);
        logic [23:0] ba;
        logic [23:0] fa;
        logic [31:0] exp_read;
        logic [7:0]  exp_bytes [$];
        logic [7:0]  g;
        int          s, l, lo, hi, nbits, lat, cs_low, sck_hi;
        bit          got;

        ba = {addr[21:0], 2'b00};
        s  = 0;
        l  = 4;
        if (we) begin
            lo = -1;
            hi = -1;
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) begin
                    if (lo < 0) lo = i;
                    hi = i;
                end
            end
            if (lo >= 0) begin
                s = lo;
                l = hi - lo + 1;
            end else begin
                l = 0;
            end
        end
        nbits = (we && l == 0) ? 0 : 32 + 8 * l;
        if (nbits != 0) begin
            fa = ba + 24'(s);
            exp_bytes.push_back(we ? 8'h02 : 8'h03);
            exp_bytes.push_back(fa[23:16]);
            exp_bytes.push_back(fa[15:8]);
            exp_bytes.push_back(fa[7:0]);
            if (we) begin
                for (int i = s; i < s + l; i++) exp_bytes.push_back(data[8*i +: 8]);
            end
        end
        exp_read = {ref_rd(ba + 24'd3), ref_rd(ba + 24'd2), ref_rd(ba + 24'd1), ref_rd(ba)};
        if (we) begin
            for (int i = s; i < s + l; i++) ref_mem[int'(ba + 24'(i))] = data[8*i +: 8];
        end else begin
            exp_rdata = exp_read;
        end

        dev_bytes.delete();
        @(negedge clk);
        sram_addr       = addr;
        sram_data_write = data;
        sram_we         = we;
        sram_wmask      = mask;
        sram_cs         = 1'b1;
        lat    = 0;
        cs_low = 0;
        sck_hi = 0;
        got    = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (mutate && n == 1) begin
                sram_addr       = $urandom;
                sram_data_write = $urandom;
                sram_wmask      = 4'($urandom);
                sram_we         = ~we;
            end
            if (spi_cs_n === 1'b0) cs_low++;
            if (spi_sck === 1'b1) sck_hi++;
            if (sram_ack === 1'b1) begin
                lat = n;
                got = 1'b1;
                break;
            end
        end
        sram_cs = 1'b0;

        checks++;
        if (!got || lat != nbits * 2 + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, nbits * 2 + 1);
        end
        checks++;
        if (cs_low != nbits * 2) begin
            errors++;
            $display("FAIL %s cs_low_cycles: got %0d expected %0d", name, cs_low, nbits * 2);
        end
        checks++;
        if (sck_hi != nbits) begin
            errors++;
            $display("FAIL %s sck_high_cycles: got %0d expected %0d", name, sck_hi, nbits);
        end
        checks++;
        if (dev_bytes.size() != nbits / 8) begin
            errors++;
            $display("FAIL %s frame_bytes: got %0d expected %0d", name, dev_bytes.size(), nbits / 8);
        end
        for (int i = 0; i < exp_bytes.size(); i++) begin
            g = (i < dev_bytes.size()) ? dev_bytes[i] : 8'hxx;
            checks++;
            if (g !== exp_bytes[i]) begin
                errors++;
                $display("FAIL %s mosi_byte%0d: got %h expected %h", name, i, g, exp_bytes[i]);
            end
        end
        checks++;
        if (sram_data_read !== exp_rdata) begin
            errors++;
            $display("FAIL %s data_read: got %h expected %h", name, sram_data_read, exp_rdata);
        end

        @(posedge clk);
        #1;
        checks++;
        if (sram_ack !== 1'b0 || spi_cs_n !== 1'b1) begin
            errors++;
            $display("FAIL %s ack_pulse: ack=%b cs_n=%b expected ack=0 cs_n=1", name, sram_ack, spi_cs_n);
        end
        $display("txn %s we=%0b addr=%h mask=%b data=%h lat=%0d rdata=%h",
                 name, we, addr, mask, data, lat, sram_data_read);
    endtask

    // -----------------------------------------------------------------------
    // Scenarios
    // -----------------------------------------------------------------------
    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({spi_cs_n, spi_sck, spi_mosi, sram_ack} !== 4'b1000 || sram_data_read !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: cs_n=%b sck=%b mosi=%b ack=%b rdata=%h expected 1 0 0 0 00000000",
                     spi_cs_n, spi_sck, spi_mosi, sram_ack, sram_data_read);
        end
        @(negedge clk);
        i_rst_n = 1'b1;
        $display("txn reset done");
    endtask

    task automatic test_word_read();
        for (int i = 0; i < 4; i++) begin
            ref_mem[32'h40 + i] = 8'h78 + 8'(i) * 8'hDE;
        end
        ref_mem[32'h40] = 8'h78; ref_mem[32'h41] = 8'h56;
        ref_mem[32'h42] = 8'h34; ref_mem[32'h43] = 8'h12;
        dev_mem[32'h40] = 8'h78; dev_mem[32'h41] = 8'h56;
        dev_mem[32'h42] = 8'h34; dev_mem[32'h43] = 8'h12;
        do_txn("word_read", 32'h10, 32'h0, 1'b0, 4'b0000, 1'b1);
        checks++;
        if (sram_data_read !== 32'h1234_5678) begin
            errors++;
            $display("FAIL word_read_value: got %h expected 12345678", sram_data_read);
        end
    endtask

    task automatic test_writes();
        do_txn("word_write", 32'h1, 32'hDEAD_BEEF, 1'b1, 4'b1111, 1'b1);
        do_txn("byte_write", 32'h1, 32'h00AA_0000, 1'b1, 4'b0100, 1'b0);
        do_txn("half_write", 32'h1, 32'hBEEF_0000, 1'b1, 4'b1100, 1'b0);
        do_txn("empty_write", 32'h1, 32'h1234_5678, 1'b1, 4'b0000, 1'b0);
        do_txn("hole_write", 32'h2, 32'h1122_3344, 1'b1, 4'b1001, 1'b0);
        do_txn("readback", 32'h1, 32'h0, 1'b0, 4'b1111, 1'b0);
        do_txn("readback2", 32'h2, 32'h0, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic test_reset_mid_read();
        bit seen_ack;
        @(negedge clk);
        sram_addr  = 32'h10;
        sram_we    = 1'b0;
        sram_wmask = 4'b0000;
        sram_cs    = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        i_rst_n = 1'b0;
        sram_cs = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({spi_cs_n, spi_sck, spi_mosi, sram_ack} !== 4'b1000 || sram_data_read !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: cs_n=%b sck=%b mosi=%b ack=%b rdata=%h expected 1 0 0 0 00000000",
                     spi_cs_n, spi_sck, spi_mosi, sram_ack, sram_data_read);
        end
        exp_rdata = '0;
        @(negedge clk);
        i_rst_n = 1'b1;
        seen_ack = 1'b0;
        repeat (150) begin
            @(posedge clk);
            #1;
            if (sram_ack === 1'b1 || spi_cs_n !== 1'b1) seen_ack = 1'b1;
        end
        checks++;
        if (seen_ack) begin
            errors++;
            $display("FAIL mid_reset_no_ack: activity after abort got 1 expected 0");
        end
        $display("txn mid_read_reset done");
        do_txn("read_after_reset", 32'h10, 32'h0, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  mask;
        for (int t = 0; t < 40; t++) begin
            r    = $urandom;
            addr = {r[31:22], 18'b0, 4'($urandom_range(0, 15))};
            we   = 1'($urandom);
            mask = 4'($urandom);
            do_txn($sformatf("rand%0d", t), addr, $urandom, we, mask, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_writes();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
